// File: rtl/parallel_prog_master.sv
// Initiator for the flash parallel-programming port: erase/write/read requests become timed XA/BS1/XTAL1/WR/OE sequences.
// Optional read-back verification of writes is compiled in when PP_VERIFY_EN is defined.
module parallel_prog_master #(
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 2,
  parameter int RD_WAIT_CYC = 2,
  parameter int RDY_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [13:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  pp_xa,
  output logic        pp_bs1,
  output logic        pp_xtal1,
  output logic        pp_wr_n,
  output logic        pp_oe_n,
  output logic [7:0]  pp_data,
  input  logic        pp_rdy,
  input  logic [15:0] pp_dout
);

  typedef enum logic [3:0] {
    IDLE, SETUP, STROBE, HOLD, WR_LO, WR_HI, WAIT_RDY, OE_LO, OE_HI, DONE
  } state_t;

  localparam logic [1:0] OP_ERASE = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [1:0]  xa_q, xa_d;
  logic        bs1_q, bs1_d;
  logic        xtal1_q, xtal1_d;
  logic        wr_n_q, wr_n_d;
  logic        oe_n_q, oe_n_d;
  logic [7:0]  data_q, data_d;
  logic        rd_mode, rd_mode_nx;
  logic [2:0]  last_step;
  logic [7:0]  cmd_byte;
`ifdef PP_VERIFY_EN
  logic        vfy_q, vfy_d;
`endif

  // A verify pass reuses the read load sequence on the write's address.
`ifdef PP_VERIFY_EN
  assign rd_mode = (op_q == OP_READ) || vfy_q;
`else
  assign rd_mode = (op_q == OP_READ);
`endif

  always_comb begin
    last_step = 3'd4;
    if (rd_mode)               last_step = 3'd2;
    else if (op_q == OP_ERASE) last_step = 3'd0;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef PP_VERIFY_EN
    vfy_d   = vfy_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          rdata_d = 16'h0000;
          err_d   = 1'b0;
          step_d  = 3'd0;
          cnt_d   = 12'd0;
`ifdef PP_VERIFY_EN
          vfy_d   = 1'b0;
`endif
          // Illegal ops idle through OE_HI (pins quiet) so the response lands two cycles later.
          if (cmd_op == OP_ILL) begin
            err_d   = 1'b1;
            state_d = OE_HI;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 12'(SETUP_CYC - 1)) begin
          cnt_d   = 12'd0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 12'(PULSE_CYC - 1)) begin
          cnt_d   = 12'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      HOLD: begin
        cnt_d = 12'd0;
        if (step_q == last_step) begin
          state_d = rd_mode ? OE_LO : WR_LO;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = SETUP;
        end
      end
      WR_LO: begin
        if (cnt_q == 12'(PULSE_CYC - 1)) begin
          cnt_d   = 12'd0;
          state_d = WR_HI;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      WR_HI: begin
        cnt_d   = 12'd0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (pp_rdy) begin
          state_d = DONE;
`ifdef PP_VERIFY_EN
          if (op_q == OP_WRITE) begin
            vfy_d   = 1'b1;
            step_d  = 3'd0;
            cnt_d   = 12'd0;
            state_d = SETUP;
          end
`endif
        end else if (cnt_q == 12'(RDY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      OE_LO: begin
        if (cnt_q == 12'(RD_WAIT_CYC - 1)) begin
          rdata_d = pp_dout;
`ifdef PP_VERIFY_EN
          if (vfy_q && (pp_dout != wdata_q)) err_d = 1'b1;
`endif
          cnt_d   = 12'd0;
          state_d = OE_HI;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      OE_HI:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are decoded from the next state so they change together with the state register.
`ifdef PP_VERIFY_EN
    rd_mode_nx = (op_d == OP_READ) || vfy_d;
`else
    rd_mode_nx = (op_d == OP_READ);
`endif
    cmd_byte = 8'h10;
    if (rd_mode_nx)            cmd_byte = 8'h02;
    else if (op_d == OP_ERASE) cmd_byte = 8'h80;

    xa_d    = 2'b11;
    bs1_d   = 1'b0;
    data_d  = 8'h00;
    xtal1_d = (state_d == STROBE);
    wr_n_d  = (state_d != WR_LO);
    oe_n_d  = (state_d != OE_LO);
    if (state_d inside {SETUP, STROBE, HOLD}) begin
      case (step_d)
        3'd0: begin xa_d = 2'b10; data_d = cmd_byte; end
        3'd1: begin xa_d = 2'b00; data_d = addr_d[7:0]; end
        3'd2: begin xa_d = 2'b00; bs1_d = 1'b1; data_d = {2'b00, addr_d[13:8]}; end
        3'd3: begin xa_d = 2'b01; data_d = wdata_d[7:0]; end
        3'd4: begin xa_d = 2'b01; bs1_d = 1'b1; data_d = wdata_d[15:8]; end
        default: ;
      endcase
    end
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      cnt_q   <= 12'd0;
      op_q    <= OP_ERASE;
      addr_q  <= 14'd0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      xa_q    <= 2'b11;
      bs1_q   <= 1'b0;
      xtal1_q <= 1'b0;
      wr_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      data_q  <= 8'h00;
`ifdef PP_VERIFY_EN
      vfy_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      xa_q    <= xa_d;
      bs1_q   <= bs1_d;
      xtal1_q <= xtal1_d;
      wr_n_q  <= wr_n_d;
      oe_n_q  <= oe_n_d;
      data_q  <= data_d;
`ifdef PP_VERIFY_EN
      vfy_q   <= vfy_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign pp_xa     = xa_q;
  assign pp_bs1    = bs1_q;
  assign pp_xtal1  = xtal1_q;
  assign pp_wr_n   = wr_n_q;
  assign pp_oe_n   = oe_n_q;
  assign pp_data   = data_q;

endmodule
